// File: rtl/dct_comput.sv
// dct_comput: captures one 13-entry log-mel frame and computes a 13-point
// DCT-II with a single time-multiplexed MAC, one multiply per cycle.
// The 13 MFCC coefficients are presented together with a one-cycle
// mfcc_ready strobe.
// Build option: define DCT_ROUND_EN to round half up before the Q1.14
// scale-down. Without it the scale-down is a floor shift.
`timescale 1ns/1ps

module dct_comput #(
    parameter int N_IN  = 13,
    parameter int N_OUT = 13,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int AW    = 36
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] log_in [0:N_IN-1],
    input  logic                 log_ready,
    output logic signed [DW-1:0] mfcc_out [0:N_OUT-1],
    output logic                 mfcc_ready,
    output logic                 busy,
    output logic                 overrun
);
    localparam int PW = DW + CW;
    localparam logic [3:0] N_LAST = 4'(N_IN - 1);
    localparam logic [3:0] K_LAST = 4'(N_OUT - 1);
    localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // cos(pi*k*(2n+1)/26) in Q1.14. The angle index is folded into the
    // first quadrant, so only 14 magnitudes are stored.
    function automatic logic signed [CW-1:0] cos_q14(input logic [3:0] k, input logic [3:0] n);
        logic [8:0]           m;
        logic [5:0]           r;
        logic [3:0]           idx;
        logic                 neg;
        logic signed [CW-1:0] mag;
        m = 9'(k) * 9'({n, 1'b1});
        r = 6'(m % 9'd52);
        if (r <= 6'd13) begin
            idx = r[3:0];
            neg = 1'b0;
        end else if (r <= 6'd26) begin
            idx = 4'(6'd26 - r);
            neg = 1'b1;
        end else if (r <= 6'd39) begin
            idx = 4'(r - 6'd26);
            neg = 1'b1;
        end else begin
            idx = 4'(6'd52 - r);
            neg = 1'b0;
        end
        case (idx)
            4'd0:    mag = CW'(16384);
            4'd1:    mag = CW'(16265);
            4'd2:    mag = CW'(15908);
            4'd3:    mag = CW'(15319);
            4'd4:    mag = CW'(14507);
            4'd5:    mag = CW'(13484);
            4'd6:    mag = CW'(12264);
            4'd7:    mag = CW'(10865);
            4'd8:    mag = CW'(9307);
            4'd9:    mag = CW'(7614);
            4'd10:   mag = CW'(5810);
            4'd11:   mag = CW'(3921);
            4'd12:   mag = CW'(1975);
            default: mag = '0;
        endcase
        return neg ? -mag : mag;
    endfunction

    // Drops the Q1.14 fraction and clamps the result to the output range.
    function automatic logic signed [DW-1:0] scale_sat(input logic signed [AW-1:0] x);
        logic signed [AW-1:0] t;
`ifdef DCT_ROUND_EN
        t = (x + AW'(8192)) >>> 14;
`else
        t = x >>> 14;
`endif
        if (t > SAT_MAX) t = SAT_MAX;
        else if (t < SAT_MIN) t = SAT_MIN;
        return t[DW-1:0];
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_k;
    logic [3:0]           r_n;
    logic signed [AW-1:0] r_acc;
    logic signed [DW-1:0] r_cap      [0:N_IN-1];
    logic signed [DW-1:0] r_buf      [0:N_OUT-1];
    logic signed [DW-1:0] r_mfcc_out [0:N_OUT-1];
    logic                 r_mfcc_ready;
    logic                 r_overrun;
    logic                 w_capture;
    logic                 w_row_end;
    logic signed [CW-1:0] w_coef;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_sum;

    assign w_coef = cos_q14(r_k, r_n);
    assign w_prod = PW'(r_cap[r_n]) * PW'(w_coef);
    assign w_sum  = r_acc + AW'(w_prod);

    assign mfcc_out   = r_mfcc_out;
    assign mfcc_ready = r_mfcc_ready;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state. A frame is accepted in IDLE and also in the DONE cycle,
    // so that back-to-back frames see no gap.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_row_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (log_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_row_end = (r_n == N_LAST);
                if (r_n == N_LAST && r_k == K_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_capture   = log_ready;
                w_state_nxt = log_ready ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture, MAC sequencing, output copy and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k          <= '0;
            r_n          <= '0;
            r_acc        <= '0;
            r_mfcc_ready <= 1'b0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < N_IN; i++) r_cap[i] <= '0;
            for (int i = 0; i < N_OUT; i++) r_mfcc_out[i] <= '0;
        end else begin
            r_mfcc_ready <= 1'b0;
            r_overrun    <= (r_state == S_RUN) && log_ready;
            if (w_capture) begin
                r_cap <= log_in;
                r_acc <= '0;
                r_k   <= '0;
                r_n   <= '0;
            end else if (r_state == S_RUN) begin
                if (w_row_end) begin
                    r_acc <= '0;
                    r_n   <= '0;
                    r_k   <= (r_k == K_LAST) ? 4'd0 : 4'(r_k + 4'd1);
                end else begin
                    r_acc <= w_sum;
                    r_n   <= 4'(r_n + 4'd1);
                end
            end
            if (r_state == S_DONE) begin
                r_mfcc_out   <= r_buf;
                r_mfcc_ready <= 1'b1;
            end
        end
    end

    // Result buffer: one entry per completed row, published in DONE.
    always_ff @(posedge clk) begin
        if (w_row_end) r_buf[r_k] <= scale_sat(w_sum);
    end

endmodule

// File: tb/tb_dct_comput.sv
`timescale 1ns/1ps

module tb_dct_comput;

    typedef logic [12:0][15:0] frm_t;
    typedef struct packed {
        frm_t               x;
        logic signed [15:0] exp0;
        logic               chk1;
        logic signed [15:0] exp1;
    } vec_t;

    localparam real PI = 3.14159265358979323846;
`ifdef DCT_ROUND_EN
    localparam logic signed [15:0] EXP_IMP1 = 16'sd993;
`else
    localparam logic signed [15:0] EXP_IMP1 = 16'sd992;
`endif

    logic               clk;
    logic               reset;
    logic signed [15:0] log_in   [0:12];
    logic               log_ready;
    logic signed [15:0] mfcc_out [0:12];
    logic               mfcc_ready;
    logic               busy;
    logic               overrun;

    int nchk;
    int nerr;

    dct_comput dut (
        .clk        (clk),
        .reset      (reset),
        .log_in     (log_in),
        .log_ready  (log_ready),
        .mfcc_out   (mfcc_out),
        .mfcc_ready (mfcc_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: DCT-II coefficients derived from the cosine itself.
    function automatic int coef(input int k, input int n);
        real x;
        x = 16384.0 * $cos(PI * real'(k * (2 * n + 1)) / 26.0);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        return -$rtoi($floor(-x + 0.5));
    endfunction

    function automatic int model(input frm_t f, input int k);
        longint acc;
        acc = 0;
        for (int n = 0; n < 13; n++) acc += longint'($signed(f[n])) * longint'(coef(k, n));
`ifdef DCT_ROUND_EN
        acc += 8192;
`endif
        acc = acc >>> 14;
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input frm_t f);
        for (int n = 0; n < 13; n++) log_in[n] = $signed(f[n]);
    endtask

    function automatic frm_t rand_frame(input int mode);
        frm_t f;
        for (int n = 0; n < 13; n++) begin
            if (mode == 0)      f[n] = 16'($urandom);
            else if (mode == 1) f[n] = 16'($urandom_range(0, 2000) - 1000);
            else                f[n] = 16'(1000 + $urandom_range(0, 19000));
        end
        return f;
    endfunction

    task automatic cmp_frame(input frm_t f, input string tag);
        for (int k = 0; k < 13; k++)
            chk($sformatf("%s_mfcc%0d", tag, k), int'(mfcc_out[k]), model(f, k));
    endtask

    // One isolated frame: capture, latency, busy window, strobe width, values.
    task automatic run_frame(input frm_t f, input string tag);
        int cyc;
        int busy_low;
        drive(f);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        drive(rand_frame(0));
        cyc = 0;
        busy_low = 0;
        while (!mfcc_ready && cyc < 400) begin
            if (!busy) busy_low++;
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 170);
        chk({tag, "_busy_gaps"}, busy_low, 0);
        chk({tag, "_busy_after_done"}, int'(busy), 0);
        cmp_frame(f, tag);
        tick();
        chk({tag, "_ready_width"}, int'(mfcc_ready), 0);
    endtask

    initial begin
        vec_t tbl [6];
        frm_t f;
        frm_t fa;
        frm_t fr [5];
        int   cyc;
        int   oc;
        int   rc;
        int   bc;
        int   nz;

        nchk = 0;
        nerr = 0;
        reset = 1'b1;
        log_ready = 1'b0;
        drive('0);
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(mfcc_ready), 0);
        chk("rst_overrun", int'(overrun), 0);
        nz = 0;
        for (int k = 0; k < 13; k++) if (mfcc_out[k] != 0) nz++;
        chk("rst_mfcc_nonzero", nz, 0);
        reset = 1'b0;
        tick();

        f = '0;
        tbl[0] = {f, 16'sd0, 1'b0, 16'sd0};
        for (int n = 0; n < 13; n++) f[n] = 16'd256;
        tbl[1] = {f, 16'sd3328, 1'b0, 16'sd0};
        f = '0;
        f[0] = 16'd1000;
        tbl[2] = {f, 16'sd1000, 1'b1, EXP_IMP1};
        for (int n = 0; n < 13; n++) f[n] = 16'h7fff;
        tbl[3] = {f, 16'sd32767, 1'b0, 16'sd0};
        for (int n = 0; n < 13; n++) f[n] = 16'h8000;
        tbl[4] = {f, 16'h8000, 1'b0, 16'sd0};
        for (int n = 0; n < 13; n++) f[n] = (n % 2 == 1) ? 16'(-500) : 16'd500;
        tbl[5] = {f, 16'sd500, 1'b0, 16'sd0};

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].x, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_mfcc0_const", i), int'(mfcc_out[0]), int'($signed(tbl[i].exp0)));
            if (tbl[i].chk1)
                chk($sformatf("vec%0d_mfcc1_const", i), int'(mfcc_out[1]), int'($signed(tbl[i].exp1)));
        end

        for (int i = 0; i < 6; i++) run_frame(rand_frame(i % 2), $sformatf("rnd%0d", i));

        // Overrun: a second strobe 50 cycles into RUN is dropped.
        fa = rand_frame(2);
        drive(fa);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        cyc = 0;
        oc = 0;
        repeat (49) begin
            tick();
            cyc++;
            if (overrun) oc++;
        end
        drive(rand_frame(0));
        log_ready = 1'b1;
        tick();
        cyc++;
        log_ready = 1'b0;
        chk("ovr_pulse_high", int'(overrun), 1);
        oc++;
        tick();
        cyc++;
        chk("ovr_pulse_low", int'(overrun), 0);
        while (!mfcc_ready && cyc < 400) begin
            tick();
            cyc++;
            if (overrun) oc++;
        end
        chk("ovr_latency", cyc, 170);
        chk("ovr_count", oc, 1);
        cmp_frame(fa, "ovr");
        tick();

        // Abort: reset 80 cycles into the next RUN clears every output.
        drive(rand_frame(2));
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        repeat (80) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nz = 0;
        for (int k = 0; k < 13; k++) if (mfcc_out[k] != 0) nz++;
        chk("abort_mfcc_nonzero", nz, 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_overrun", int'(overrun), 0);
        chk("abort_ready", int'(mfcc_ready), 0);
        rc = 0;
        bc = 0;
        repeat (200) begin
            tick();
            if (mfcc_ready) rc++;
            if (busy) bc++;
        end
        chk("abort_no_ready", rc, 0);
        chk("abort_stays_idle", bc, 0);

        run_frame(rand_frame(0), "recover");

        // Back-to-back: log_ready held high; each DONE edge captures the next frame.
        for (int i = 0; i < 5; i++) fr[i] = rand_frame(i % 2);
        drive(fr[0]);
        log_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(fr[i + 1]);
            cyc = 0;
            oc = 0;
            do begin
                tick();
                cyc++;
                if (overrun) oc++;
            end while (!mfcc_ready && cyc < 400);
            chk($sformatf("b2b%0d_period", i), cyc, 170);
            chk($sformatf("b2b%0d_overruns", i), oc, 169);
            chk($sformatf("b2b%0d_busy", i), int'(busy), 1);
            cmp_frame(fr[i], $sformatf("b2b%0d", i));
        end
        tick();
        chk("b2b_ready_width", int'(mfcc_ready), 0);
        log_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
